// File: rtl/solar_scan_ctrl.sv
// solar_scan_ctrl
//   Scan sequencer for the solar panel monitor. Steps an external analog mux
//   across NCH panel sensors and runs one ADC conversion per channel. It uses
//   a start/done handshake with a timeout. Each reading is compared against a
//   low-output threshold, and a debounced fault flag is kept for each panel.
//
// Ports
//   wb_clk_i     in   system clock
//   wb_rst_i     in   synchronous reset, active-high
//   enable       in   permit scanning (looked at only between scans)
//   threshold    in   DW-bit unsigned low-output threshold (reading < threshold is low)
//   adc_done     in   conversion-complete pulse; adc_data is valid in the same cycle
//   adc_data     in   DW-bit ADC result
//   mux_sel      out  analog mux channel select (holds its value while idle)
//   adc_start    out  1-cycle conversion request
//   sample_valid out  1-cycle strobe qualifying sample_ch/sample_data/sample_tmo
//   sample_ch    out  channel of the reported sample
//   sample_data  out  captured reading (0 on timeout)
//   sample_tmo   out  reported sample was a timeout
//   fault        out  per-channel debounced low-output fault
//   busy         out  a scan step is in progress (SELECT/CONVERT/STORE)
module solar_scan_ctrl #(
  parameter int NCH    = 3,
  parameter int DW     = 8,
  parameter int SETTLE = 4,
  parameter int TMO    = 64,
  parameter int PERIOD = 1000,
  parameter int FCNT   = 3,
  localparam int CW    = $clog2(NCH)
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           enable,
  input  logic [DW-1:0]  threshold,
  input  logic           adc_done,
  input  logic [DW-1:0]  adc_data,
  output logic [CW-1:0]  mux_sel,
  output logic           adc_start,
  output logic           sample_valid,
  output logic [CW-1:0]  sample_ch,
  output logic [DW-1:0]  sample_data,
  output logic           sample_tmo,
  output logic [NCH-1:0] fault,
  output logic           busy
);

  // One step counter serves both SELECT (settle) and CONVERT (timeout).
  localparam int CMAX = (SETTLE > TMO) ? SETTLE : TMO;
  localparam int CNTW = $clog2(CMAX + 1);
  localparam int PW   = $clog2(PERIOD + 1);
  localparam int FW   = $clog2(FCNT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    CONVERT = 3'd2,
    STORE   = 3'd3,
    WAIT    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [CW-1:0]   mux_sel_q, mux_sel_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]   tmr_q, tmr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            tmo_q, tmo_d;
  logic            capture;
  logic            low_d;
  logic            scan_start;
  logic            period_done;

  // The period timer saturates, so a scan that overruns PERIOD still sees
  // period_done when it finishes and goes straight into the next scan.
  assign period_done = (tmr_q == PW'(PERIOD - 1));

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    capture    = 1'b0;
    scan_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = SELECT;
          ch_d       = '0;
          scan_start = 1'b1;
        end
      end
      SELECT: begin
        if (cnt_q == CNTW'(SETTLE - 1)) state_d = CONVERT;
      end
      CONVERT: begin
        // adc_done takes priority over the timeout on the expiry cycle.
        if (adc_done) begin
          state_d = STORE;
          capture = 1'b1;
          data_d  = adc_data;
          tmo_d   = 1'b0;
        end else if (cnt_q == CNTW'(TMO - 1)) begin
          state_d = STORE;
          capture = 1'b1;
          data_d  = '0;
          tmo_d   = 1'b1;
        end
      end
      STORE: begin
        if (ch_q != CW'(NCH - 1)) begin
          ch_d    = ch_q + 1'b1;
          state_d = SELECT;
        end else begin
          ch_d = '0;
          if (!period_done) begin
            state_d = WAIT;
          end else if (enable) begin
            state_d    = SELECT;
            scan_start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT: begin
        if (period_done) begin
          if (enable) begin
            state_d    = SELECT;
            scan_start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeout counts as a low reading for the debounce.
    low_d = tmo_d || (adc_data < threshold);

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == SELECT) || (state_q == CONVERT)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end

    if (scan_start) begin
      tmr_d = '0;
    end else if (period_done) begin
      tmr_d = tmr_q;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end

    mux_sel_d = (state_d == SELECT) ? ch_d : mux_sel_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      mux_sel_q <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      data_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      mux_sel_q <= mux_sel_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
    end
  end

  // The debounce counters update on the capture edge. That puts the new
  // fault value on the bus in the same cycle as sample_valid.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_fault
      logic [FW-1:0] fcnt_q;
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          fcnt_q <= '0;
        end else if (capture && (ch_q == CW'(gi))) begin
          if (!low_d) begin
            fcnt_q <= '0;
          end else if (fcnt_q != FW'(FCNT)) begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
      end
      assign fault[gi] = (fcnt_q == FW'(FCNT));
    end
  endgenerate

  assign mux_sel      = mux_sel_q;
  assign adc_start    = (state_q == CONVERT) && (cnt_q == '0);
  assign sample_valid = (state_q == STORE);
  assign sample_ch    = sample_valid ? ch_q : '0;
  assign sample_data  = sample_valid ? data_q : '0;
  assign sample_tmo   = sample_valid && tmo_q;
  assign busy         = (state_q == SELECT) || (state_q == CONVERT) || (state_q == STORE);

endmodule

// File: tb/tb_solar_scan_ctrl.sv
// Directed testbench for solar_scan_ctrl.
// The main instance uses the default parameters (PERIOD=1000).
// A second instance uses PERIOD=10. Its adc_done is looped back from adc_start,
// so its scans run back-to-back.
module tb_solar_scan_ctrl;

  logic       clk = 1'b0;
  logic       wb_rst_i, enable, adc_done;
  logic [7:0] threshold, adc_data;
  logic [1:0] mux_sel, sample_ch;
  logic       adc_start, sample_valid, sample_tmo, busy;
  logic [7:0] sample_data;
  logic [2:0] fault;

  logic       rst2, enable2, adc_done2, adc_start2, sample_valid2, sample_tmo2, busy2;
  logic [7:0] threshold2, adc_data2, sample_data2;
  logic [1:0] mux_sel2, sample_ch2;
  logic [2:0] fault2;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  solar_scan_ctrl #(.NCH(3), .DW(8), .SETTLE(4), .TMO(64), .PERIOD(1000), .FCNT(3)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .enable(enable), .threshold(threshold),
    .adc_done(adc_done), .adc_data(adc_data), .mux_sel(mux_sel), .adc_start(adc_start),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .sample_tmo(sample_tmo), .fault(fault), .busy(busy)
  );

  assign adc_done2  = adc_start2;
  assign adc_data2  = 8'h80;
  assign threshold2 = 8'h40;

  solar_scan_ctrl #(.NCH(3), .DW(8), .SETTLE(4), .TMO(64), .PERIOD(10), .FCNT(3)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst2), .enable(enable2), .threshold(threshold2),
    .adc_done(adc_done2), .adc_data(adc_data2), .mux_sel(mux_sel2), .adc_start(adc_start2),
    .sample_valid(sample_valid2), .sample_ch(sample_ch2), .sample_data(sample_data2),
    .sample_tmo(sample_tmo2), .fault(fault2), .busy(busy2)
  );

  // Cycle stamps of channel-0 conversion starts. The settle time is fixed,
  // so their spacing equals the spacing of the scan starts.
  int cyc = 0;
  int prev0 = 0, diff0 = 0;
  bit have0 = 0;
  int prev2 = 0, diff2 = 0, gaps2 = 0;
  bit have2 = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (adc_start && mux_sel == 2'd0) begin
      if (have0) diff0 = cyc - prev0;
      prev0 = cyc;
      have0 = 1;
    end
    if (have2 && !busy2) gaps2++;
    if (adc_start2 && mux_sel2 == 2'd0) begin
      if (have2) diff2 = cyc - prev2;
      prev2 = cyc;
      have2 = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (adc_start !== 1'b1 && n < 1200) begin
      step();
      n++;
    end
    check(tag, adc_start, 1);
  endtask

  // Wait for adc_start, answer after dly cycles with data d, and stop in the STORE cycle.
  task automatic convert(input int dly, input logic [7:0] d, input bit drop_en, input string tag);
    wait_start({tag, "_start"});
    if (drop_en) enable = 1'b0;
    repeat (dly) step();
    adc_done = 1'b1;
    adc_data = d;
    step();
    adc_done = 1'b0;
    check({tag, "_valid"}, sample_valid, 1);
    check({tag, "_data"}, sample_data, d);
  endtask

  initial begin
    int bad;
    wb_rst_i = 1'b1; rst2 = 1'b1; enable = 1'b0; enable2 = 1'b0;
    adc_done = 1'b0; adc_data = 8'h00; threshold = 8'h40;
    repeat (3) step();
    check("reset_outputs",
          {13'd0, mux_sel, adc_start, sample_valid, sample_ch, sample_data, sample_tmo, fault, busy}, 0);
    wb_rst_i = 1'b0; rst2 = 1'b0;
    step();
    enable2 = 1'b1;
    check("idle_busy", busy, 0);

    // Test 1: exact timing of the first channel.
    enable = 1'b1;                       // cycle t0
    for (int i = 1; i <= 4; i++) begin
      step();                            // t0+1 .. t0+4
      check($sformatf("t1_sel%0d_mux", i), mux_sel, 0);
      check($sformatf("t1_sel%0d_busy", i), busy, 1);
      check($sformatf("t1_sel%0d_start", i), adc_start, 0);
    end
    step();                              // t0+5
    check("t1_adc_start", adc_start, 1);
    step();                              // t0+6
    check("t1_start_one_cycle", adc_start, 0);
    step();                              // t0+7
    check("t1_no_valid_yet", sample_valid, 0);
    adc_done = 1'b1; adc_data = 8'h80;
    step();                              // t0+8
    adc_done = 1'b0;
    check("t1_valid", sample_valid, 1);
    check("t1_ch", sample_ch, 0);
    check("t1_data", sample_data, 8'h80);
    check("t1_tmo", sample_tmo, 0);
    convert(1, 8'h10, 0, "s1c1");
    check("s1c1_ch", sample_ch, 1);
    check("s1c1_fault", fault, 3'b000);
    convert(2, 8'h90, 0, "s1c2");
    check("s1c2_ch", sample_ch, 2);
    step();
    check("wait_busy", busy, 0);
    check("wait_mux_hold", mux_sel, 2);

    // Tests 2 and 4: debounce on channel 1, and the scan period.
    convert(1, 8'h80, 0, "s2c0");
    check("period_1000", diff0, 1000);
    convert(1, 8'h10, 0, "s2c1");
    check("s2c1_fault", fault, 3'b000);
    convert(1, 8'h90, 0, "s2c2");
    convert(1, 8'h80, 0, "s3c0");
    convert(1, 8'h10, 0, "s3c1");
    check("s3c1_fault_set", fault, 3'b010);
    convert(1, 8'h90, 0, "s3c2");
    convert(1, 8'h80, 0, "s4c0");
    convert(1, 8'h10, 0, "s4c1");
    check("s4c1_fault_held", fault, 3'b010);
    convert(1, 8'h90, 0, "s4c2");
    convert(0, 8'h40, 0, "s5c0");        // done on the adc_start cycle; equal to threshold
    check("s5c0_fault", fault, 3'b010);
    convert(1, 8'h50, 0, "s5c1");
    check("s5c1_fault_clear", fault, 3'b000);
    convert(1, 8'h90, 0, "s5c2");

    // Test 3: timeout on channel 2, then adc_done on the expiry cycle.
    convert(1, 8'h80, 0, "s6c0");
    convert(1, 8'h10, 0, "s6c1");
    wait_start("s6c2_start");
    repeat (63) step();                  // 64th CONVERT cycle = expiry
    check("s6c2_no_early_valid", sample_valid, 0);
    step();
    check("tmo_valid", sample_valid, 1);
    check("tmo_flag", sample_tmo, 1);
    check("tmo_data", sample_data, 0);
    check("tmo_ch", sample_ch, 2);
    check("tmo_fault", fault, 3'b000);
    step();
    check("tmo_then_wait", busy, 0);
    convert(1, 8'h80, 0, "s7c0");
    convert(1, 8'h10, 0, "s7c1");
    wait_start("s7c2_start");
    repeat (63) step();
    adc_done = 1'b1; adc_data = 8'h77;
    step();
    adc_done = 1'b0;
    check("expiry_valid", sample_valid, 1);
    check("expiry_tmo", sample_tmo, 0);
    check("expiry_data", sample_data, 8'h77);

    // Test 5: drop enable during channel-1 CONVERT.
    convert(1, 8'h80, 0, "s8c0");
    convert(1, 8'h10, 1, "s8c1");
    check("s8c1_ch", sample_ch, 1);
    check("s8c1_fault_set", fault, 3'b010);
    convert(1, 8'h90, 0, "s8c2");
    check("s8c2_ch", sample_ch, 2);
    step();
    check("drop_busy", busy, 0);
    bad = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (busy || adc_start) bad++;
    end
    check("drop_stays_idle", bad, 0);

    // Test 6: reset during CONVERT, with a late adc_done after reset release.
    enable = 1'b1;
    wait_start("t6_start");
    wb_rst_i = 1'b1; enable = 1'b0;
    step();
    wb_rst_i = 1'b0;
    check("t6_reset_outputs",
          {13'd0, mux_sel, adc_start, sample_valid, sample_ch, sample_data, sample_tmo, fault, busy}, 0);
    step();
    adc_done = 1'b1; adc_data = 8'h10;
    step();
    adc_done = 1'b0;
    check("t6_late_done_valid", sample_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_fault", fault, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (sample_valid || busy) bad++;
    end
    check("t6_quiet", bad, 0);

    // Test 4b: PERIOD=10 instance runs back-to-back (18-cycle scans, no WAIT).
    check("p10_spacing", diff2, 18);
    check("p10_no_wait", gaps2, 0);
    check("p10_ran", have2, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
